// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_scanner                                                |
// | Purpose  : Memory-mapped 4x4 key-matrix scanner. Drives one row low at a |
// |            time, samples the synchronized columns, assembles a 16-bit    |
// |            frame, debounces across identical frames and latches the      |
// |            lowest newly pressed key as a code with an interrupt request. |
// | Ports    : clk, reset   - clock, synchronous active-high reset           |
// |            row_o[3:0]   - row drive, active-low, one-hot-low             |
// |            col_i[3:0]   - column sense, active-low, asynchronous         |
// |            ADD_I[31:0]  - bus byte address                               |
// |            DAT_I[31:0]  - bus write data                                 |
// |            WE_I         - bus write enable (single cycle)                |
// |            DAT_O[31:0]  - bus read data, combinational from ADD_I        |
// |            irq          - registered level interrupt (valid & ie)        |
// | Registers: BASE_ADDR+0 STATUS {valid, ovf, 10'b0, code[3:0], stable}    |
// |            BASE_ADDR+4 CTRL   W: bit0 ack, bit1 ie; R: {30'b0, ie, 1'b0} |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int          SCAN_DIV  = 1000,
  parameter int          DEBOUNCE  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f40
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_o,
  input  logic [3:0]  col_i,
  input  logic [31:0] ADD_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  output logic [31:0] DAT_O,
  output logic        irq
);

  localparam int               c_CNT_W       = $clog2(SCAN_DIV + 1);
  localparam int               c_SC_W        = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(SCAN_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_SC_W-1:0]  c_SC_MAX    = c_SC_W'(DEBOUNCE - 1);
  localparam logic [31:0]      c_STATUS_ADDR = BASE_ADDR;
  localparam logic [31:0]      c_CTRL_ADDR   = BASE_ADDR + 32'd4;

  // ---------------------------------------------------------------------
  // Column synchronizer. Idle level is all-high (pull-ups), so reset there
  // to avoid a phantom press in the first frame.
  // ---------------------------------------------------------------------
  logic [3:0] r_col_meta;
  logic [3:0] r_col_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
    end else begin
      r_col_meta <= col_i;
      r_col_sync <= r_col_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Row scan timing
  // ---------------------------------------------------------------------
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_row_idx;
  logic               w_sample;
  logic               w_frame_end;

  // The slot ends in the cycle the down-counter reads 1; sampling there
  // leaves at least two settle cycles after the row change for the
  // synchronizer to carry the new column level.
  assign w_sample    = (r_cnt == c_CNT_ONE);
  assign w_frame_end = w_sample && (r_row_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= c_CNT_LOAD;
      r_row_idx <= 2'd0;
    end else if (w_sample) begin
      r_cnt     <= c_CNT_LOAD;
      r_row_idx <= r_row_idx + 2'd1;
    end else begin
      r_cnt     <= r_cnt - c_CNT_ONE;
    end
  end

  assign row_o = ~(4'b0001 << r_row_idx);

  // ---------------------------------------------------------------------
  // Raw frame assembly. Key index = row*4 + col, pressed = 1.
  // ---------------------------------------------------------------------
  logic [15:0] r_raw;
  logic [15:0] w_raw_next;

  always_comb begin
    w_raw_next = r_raw;
    if (w_sample) begin
      w_raw_next[{r_row_idx, 2'b00} +: 4] = ~r_col_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_raw <= 16'h0000;
    end else begin
      r_raw <= w_raw_next;
    end
  end

  // ---------------------------------------------------------------------
  // Frame debounce. w_raw_next already holds the row-3 sample at frame end,
  // so the completed frame is compared against the previous one directly.
  // ---------------------------------------------------------------------
  logic [15:0]       r_frame_q;
  logic [c_SC_W-1:0] r_same_cnt;
  logic              r_frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_q    <= 16'h0000;
      r_same_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        r_frame_q <= w_raw_next;
        if (w_raw_next == r_frame_q) begin
          if (r_same_cnt != c_SC_MAX) begin
            r_same_cnt <= r_same_cnt + c_SC_W'(1);
          end
        end else begin
          r_same_cnt <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stable bitmap and press latch
  // ---------------------------------------------------------------------
  logic [15:0] r_stable;
  logic [3:0]  r_code;
  logic        r_valid;
  logic        r_ovf;
  logic        r_ie;
  logic        r_irq;

  logic        w_stable_upd;
  logic [15:0] w_newp;
  logic [3:0]  w_low_idx;
  logic        w_ctrl_wr;
  logic        w_ack;
  logic        w_valid_nxt;
  logic        w_ovf_nxt;
  logic [3:0]  w_code_nxt;

  // For DEBOUNCE=1 the counter never leaves 0 == c_SC_MAX, so every frame
  // updates the stable bitmap.
  assign w_stable_upd = r_frame_done && (r_same_cnt == c_SC_MAX);
  assign w_newp       = w_stable_upd ? (r_frame_q & ~r_stable) : 16'h0000;
  assign w_ctrl_wr    = WE_I && (ADD_I == c_CTRL_ADDR);
  assign w_ack        = w_ctrl_wr && DAT_I[0];

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_newp[i]) begin
        w_low_idx = 4'(i);
      end
    end
  end

  // The acknowledge is applied before the press evaluation, so a press
  // landing in the ack cycle is latched fresh rather than flagged overflow.
  always_comb begin
    w_valid_nxt = w_ack ? 1'b0 : r_valid;
    w_ovf_nxt   = w_ack ? 1'b0 : r_ovf;
    w_code_nxt  = r_code;
    if (|w_newp) begin
      if (!w_valid_nxt) begin
        w_valid_nxt = 1'b1;
        w_code_nxt  = w_low_idx;
      end else begin
        w_ovf_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 16'h0000;
      r_code   <= 4'd0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ie     <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_stable_upd) begin
        r_stable <= r_frame_q;
      end
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_ctrl_wr) begin
        r_ie <= DAT_I[1];
      end
      r_irq <= r_valid & r_ie;
    end
  end

  assign irq = r_irq;

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    DAT_O = 32'h0000_0000;
    if (ADD_I == c_STATUS_ADDR) begin
      DAT_O = {r_valid, r_ovf, 10'b0, r_code, r_stable};
    end else if (ADD_I == c_CTRL_ADDR) begin
      DAT_O = {30'b0, r_ie, 1'b0};
    end
  end

  // Upper write-data bits have no function in this block.
  logic w_unused_dat;
  assign w_unused_dat = &{1'b0, DAT_I[31:2]};

endmodule
`default_nettype wire
